memory_unit: RTL and testbench
==============================

MEMORY_UNIT -- requirements
Module: memory_unit

Interface
REQ-001 clock  in  1  single system clock; all state updates on posedge.
REQ-002 reset  in  1  synchronous, active-low reset; sampled on posedge clock only.
REQ-003 memory_op  in  memory_op_e  command from the control unit; members used: MEM_NOP, MEM_READ, MEM_WRITE, MEM_LOAD_MAR, MEM_LOAD_PC, MEM_INC_PC.
REQ-004 data_word_selector  in  1  address source: 0 = PC, 1 = MAR.
REQ-005 bus_selector  in  1  1 = memory unit drives the shared bus.
REQ-006 bus  in  8  shared bus value: write data and MAR/PC load value.
REQ-007 bus_out  out  8  last read data register.
REQ-008 bus_drive  out  1  bus_out valid on shared bus; equals bus_selector combinationally.
REQ-009 stall  out  1  access in progress; control unit holds its state while high.
REQ-010 pc, mar  out  8 each  program counter and memory address register.
REQ-011 mem_req, mem_we  out  1 each  external memory request and write strobe.
REQ-012 mem_addr, mem_wdata  out  8 each  external address and write data.
REQ-013 mem_rdata  in  8  external read data; valid when mem_ack is high.
REQ-014 mem_ack  in  1  external access complete, single-cycle pulse.
REQ-015 mem_err  out  1  sticky timeout flag.

Function
REQ-016 FSM states: IDLE and ACCESS; stall SHALL be high exactly while in ACCESS.
REQ-017 memory_op SHALL be decoded only in IDLE; in ACCESS every op is ignored; undefined encodings SHALL act as MEM_NOP.
REQ-018 MEM_LOAD_MAR: mar <= bus at the same edge, no stall.
REQ-019 MEM_LOAD_PC: pc <= bus at the same edge, no stall.
REQ-020 MEM_INC_PC: pc <= pc + 1, modulo 256 (0xFF -> 0x00).
REQ-021 MEM_READ/MEM_WRITE in IDLE: latch mem_addr (PC or MAR per data_word_selector), latch mem_wdata <= bus on write, enter ACCESS at the same edge.
REQ-022 In ACCESS: mem_req = 1; mem_we = 1 for write only; mem_addr and mem_wdata SHALL hold stable.
REQ-023 mem_ack sampled high in ACCESS: on read, bus_out <= mem_rdata; return to IDLE; mem_req drops the following cycle (latency from acceptance: 1 cycle + memory wait).
REQ-024 Read with data_word_selector = 0 (fetch) SHALL increment pc, with wrap, at the ack edge; no pc change on MAR-addressed reads or any write.
REQ-025 mem_ack outside ACCESS SHALL be ignored.
REQ-026 4-bit wait counter clears on ACCESS entry; 15 ACCESS cycles without ack -> abort to IDLE, mem_err <= 1, bus_out and pc unchanged.
REQ-027 mem_err SHALL stay set until reset; further accesses proceed normally.

Reset
REQ-028 reset = 0 at posedge: state IDLE; pc, mar, bus_out, mem_addr, mem_wdata = 0x00; mem_req, mem_we, stall, mem_err = 0; wait counter = 0.
REQ-029 Reset during ACCESS SHALL abort the access; mem_req low from the next cycle; a concurrent mem_ack is discarded.
REQ-030 Reset SHALL take priority over every memory_op and mem_ack in the same cycle.

Verification
REQ-031 Reset, then MEM_LOAD_PC bus = 0x10 -> pc = 0x10, stall stays 0.
REQ-032 pc = 0x10, MEM_READ, dws = 0; ack after 2 cycles with rdata = 0xA5 -> mem_addr = 0x10, stall high 3 cycles, bus_out = 0xA5, pc = 0x11.
REQ-033 MEM_LOAD_MAR 0x80; MEM_WRITE, dws = 1, bus = 0x3C; ack -> mem_addr = 0x80, mem_we = 1, mem_wdata = 0x3C, pc unchanged.
REQ-034 pc = 0xFF; MEM_INC_PC -> pc = 0x00; fetch at 0xFF -> pc = 0x00 after ack.
REQ-035 MEM_READ with no ack -> stall high 15 cycles, then IDLE, mem_err = 1, bus_out unchanged.
REQ-036 Reset asserted during ACCESS with simultaneous ack -> all outputs at reset values, bus_out = 0x00.

Source files
------------

// File: rtl/memory_unit.sv
// rtl/memory_unit.sv - PC/MAR registers and handshaked single-word external memory access
//
// Ports:
//   clock, reset          system clock; synchronous active-low reset
//   memory_op             command from the control unit (decoded only while idle)
//   data_word_selector    access address source: 0 = pc, 1 = mar
//   bus_selector, bus     shared-bus drive request and shared-bus value
//   bus_out, bus_drive    last read data and its shared-bus enable
//   stall                 high while an external access is outstanding
//   pc, mar               program counter and memory address register
//   mem_req/we/addr/wdata external memory request side
//   mem_rdata, mem_ack    external memory response side
//   mem_err               sticky access-timeout flag

package memory_unit_pkg;
   typedef enum logic [2:0] {
      MEM_NOP      = 3'd0,
      MEM_READ     = 3'd1,
      MEM_WRITE    = 3'd2,
      MEM_LOAD_MAR = 3'd3,
      MEM_LOAD_PC  = 3'd4,
      MEM_INC_PC   = 3'd5
   } memory_op_e;
endpackage

module memory_unit
   import memory_unit_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  memory_op_e memory_op,
   input  logic       data_word_selector,
   input  logic       bus_selector,
   input  logic [7:0] bus,
   output logic [7:0] bus_out,
   output logic       bus_drive,
   output logic       stall,
   output logic [7:0] pc,
   output logic [7:0] mar,
   output logic       mem_req,
   output logic       mem_we,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   input  logic [7:0] mem_rdata,
   input  logic       mem_ack,
   output logic       mem_err
);

   typedef enum logic {IDLE, ACCESS} state_e;

   // Index of the last ACCESS cycle allowed before the access is abandoned
   // (the counter starts at 0 on the first ACCESS cycle, so this is cycle 15).
   localparam logic [3:0] WAIT_LAST = 4'd14;

   state_e     state;
   state_e     state_next;
   logic [3:0] wait_cnt;
   logic       is_write;
   logic       is_fetch;
   logic       start_access;
   logic       complete;
   logic       timeout;

   always_comb begin
      state_next   = state;
      start_access = 1'b0;
      complete     = 1'b0;
      timeout      = 1'b0;
      case (state)
         IDLE: begin
            if (memory_op == MEM_READ || memory_op == MEM_WRITE) begin
               start_access = 1'b1;
               state_next   = ACCESS;
            end
         end
         ACCESS: begin
            // An ack on the final allowed cycle still completes the access.
            if (mem_ack) begin
               complete   = 1'b1;
               state_next = IDLE;
            end else if (wait_cnt == WAIT_LAST) begin
               timeout    = 1'b1;
               state_next = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= IDLE;
         pc        <= 8'h00;
         mar       <= 8'h00;
         bus_out   <= 8'h00;
         mem_addr  <= 8'h00;
         mem_wdata <= 8'h00;
         mem_err   <= 1'b0;
         wait_cnt  <= 4'd0;
         is_write  <= 1'b0;
         is_fetch  <= 1'b0;
      end else begin
         state <= state_next;

         if (state == IDLE) begin
            case (memory_op)
               MEM_LOAD_MAR: mar <= bus;
               MEM_LOAD_PC:  pc  <= bus;
               MEM_INC_PC:   pc  <= pc + 8'd1;
               default: ;
            endcase
         end

         if (start_access) begin
            mem_addr <= data_word_selector ? mar : pc;
            is_write <= (memory_op == MEM_WRITE);
            // Only pc-addressed reads are instruction fetches that advance pc.
            is_fetch <= (memory_op == MEM_READ) && !data_word_selector;
            wait_cnt <= 4'd0;
            if (memory_op == MEM_WRITE) begin
               mem_wdata <= bus;
            end
         end

         if (complete) begin
            if (!is_write) begin
               bus_out <= mem_rdata;
            end
            if (is_fetch) begin
               pc <= pc + 8'd1;
            end
         end else if (state == ACCESS) begin
            wait_cnt <= wait_cnt + 4'd1;
         end

         if (timeout) begin
            mem_err <= 1'b1;
         end
      end
   end

   assign stall     = (state == ACCESS);
   assign mem_req   = (state == ACCESS);
   assign mem_we    = (state == ACCESS) && is_write;
   assign bus_drive = bus_selector;

endmodule

// File: tb/tb_memory_unit.sv
// tb/tb_memory_unit.sv - randomized self-checking bench for memory_unit against a transaction-level model

module tb_memory_unit;
   import memory_unit_pkg::*;

   logic       clock;
   logic       reset;
   memory_op_e memory_op;
   logic       data_word_selector;
   logic       bus_selector;
   logic [7:0] bus;
   logic [7:0] bus_out;
   logic       bus_drive;
   logic       stall;
   logic [7:0] pc;
   logic [7:0] mar;
   logic       mem_req;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   logic       mem_ack;
   logic       mem_err;

   int checks = 0;
   int errors = 0;

   // Architectural model state
   logic [7:0] m_pc, m_mar, m_bus_out, m_addr, m_wdata;
   logic       m_err;

   memory_unit dut (
      .clock              (clock),
      .reset              (reset),
      .memory_op          (memory_op),
      .data_word_selector (data_word_selector),
      .bus_selector       (bus_selector),
      .bus                (bus),
      .bus_out            (bus_out),
      .bus_drive          (bus_drive),
      .stall              (stall),
      .pc                 (pc),
      .mar                (mar),
      .mem_req            (mem_req),
      .mem_we             (mem_we),
      .mem_addr           (mem_addr),
      .mem_wdata          (mem_wdata),
      .mem_rdata          (mem_rdata),
      .mem_ack            (mem_ack),
      .mem_err            (mem_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic model_reset();
      m_pc = 8'h00; m_mar = 8'h00; m_bus_out = 8'h00;
      m_addr = 8'h00; m_wdata = 8'h00; m_err = 1'b0;
   endtask

   task automatic apply_reset(input logic [2:0] op_during, input logic ack_during, input string name);
      @(negedge clock);
      reset = 1'b0;
      memory_op = memory_op_e'(op_during);
      bus = 8'($urandom);
      mem_ack = ack_during;
      mem_rdata = 8'($urandom);
      @(negedge clock);
      reset = 1'b1;
      memory_op = MEM_NOP;
      mem_ack = 1'b0;
      model_reset();
      checks++;
      if ({pc, mar, bus_out, mem_addr, mem_wdata} !== {m_pc, m_mar, m_bus_out, m_addr, m_wdata}) begin
         errors++;
         $display("FAIL %s_regs actual=%h required=%h", name,
                  {pc, mar, bus_out, mem_addr, mem_wdata}, {m_pc, m_mar, m_bus_out, m_addr, m_wdata});
      end
      checks++;
      if ({mem_req, mem_we, stall, mem_err} !== 4'b0000) begin
         errors++;
         $display("FAIL %s_flags actual=%b required=0000", name, {mem_req, mem_we, stall, mem_err});
      end
   endtask

   // Single-cycle register ops; random acks while idle must be ignored.
   task automatic do_simple(input logic [2:0] op, input logic [7:0] data, input string name);
      @(negedge clock);
      memory_op = memory_op_e'(op);
      bus = data;
      data_word_selector = 1'($urandom);
      mem_ack = 1'($urandom);
      mem_rdata = 8'($urandom);
      @(negedge clock);
      memory_op = MEM_NOP;
      mem_ack = 1'b0;
      case (op)
         3'd3: m_mar = data;
         3'd4: m_pc = data;
         3'd5: m_pc = 8'((int'(m_pc) + 1) % 256);
         default: ;
      endcase
      checks++;
      if ({pc, mar, bus_out, mem_err, stall, mem_req} !== {m_pc, m_mar, m_bus_out, m_err, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name,
                  {pc, mar, bus_out, mem_err, stall, mem_req}, {m_pc, m_mar, m_bus_out, m_err, 1'b0, 1'b0});
      end
   endtask

   // One read or write; ack arrives after wait_n idle ACCESS cycles, or never if that exceeds 14.
   task automatic do_access(input logic [2:0] op, input logic dws, input logic [7:0] data,
                            input int wait_n, input logic [7:0] rdata, input string name);
      logic we;
      logic acked;
      int   k;
      we = (op == 3'd2);
      m_addr = dws ? m_mar : m_pc;
      if (we) m_wdata = data;
      @(negedge clock);
      memory_op = memory_op_e'(op);
      data_word_selector = dws;
      bus = data;
      mem_ack = 1'($urandom);
      mem_rdata = 8'($urandom);
      k = 0;
      acked = 1'b0;
      do begin
         @(negedge clock);
         k++;
         checks++;
         if ({stall, mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, we, m_addr, m_wdata}) begin
            errors++;
            $display("FAIL %s_access_cycle%0d actual=%h required=%h", name, k,
                     {stall, mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, we, m_addr, m_wdata});
         end
         // Commands during an access must be ignored.
         memory_op = memory_op_e'($urandom_range(0, 7));
         bus = 8'($urandom);
         data_word_selector = 1'($urandom);
         bus_selector = 1'($urandom);
         acked = (k == wait_n + 1);
         mem_ack = acked;
         mem_rdata = acked ? rdata : 8'($urandom);
         #1;
         checks++;
         if (bus_drive !== bus_selector) begin
            errors++;
            $display("FAIL %s_bus_drive actual=%b required=%b", name, bus_drive, bus_selector);
         end
      end while (!acked && k < 15);
      @(negedge clock);
      memory_op = MEM_NOP;
      mem_ack = 1'b0;
      if (acked) begin
         if (!we) m_bus_out = rdata;
         if (!we && !dws) m_pc = 8'((int'(m_pc) + 1) % 256);
      end else begin
         m_err = 1'b1;
      end
      checks++;
      if ({stall, mem_req, mem_we} !== 3'b000) begin
         errors++;
         $display("FAIL %s_release actual=%b required=000", name, {stall, mem_req, mem_we});
      end
      checks++;
      if ({pc, mar, bus_out, mem_err} !== {m_pc, m_mar, m_bus_out, m_err}) begin
         errors++;
         $display("FAIL %s_result actual=%h required=%h", name,
                  {pc, mar, bus_out, mem_err}, {m_pc, m_mar, m_bus_out, m_err});
      end
   endtask

   task automatic test_reset();
      apply_reset(3'd4, 1'b1, "reset_with_load_pc");
   endtask

   task automatic test_fetch_and_write();
      do_simple(3'd4, 8'h10, "load_pc_10");
      do_access(3'd1, 1'b0, 8'h00, 2, 8'hA5, "fetch_10");
      checks++;
      if ({pc, bus_out, mem_addr} !== {8'h11, 8'hA5, 8'h10}) begin
         errors++;
         $display("FAIL fetch_10_const actual=%h required=11a510", {pc, bus_out, mem_addr});
      end
      do_simple(3'd3, 8'h80, "load_mar_80");
      do_access(3'd2, 1'b1, 8'h3C, 1, 8'h00, "write_80");
      checks++;
      if ({pc, mem_addr, mem_wdata, bus_out} !== {8'h11, 8'h80, 8'h3C, 8'hA5}) begin
         errors++;
         $display("FAIL write_80_const actual=%h required=11803ca5", {pc, mem_addr, mem_wdata, bus_out});
      end
   endtask

   task automatic test_pc_wrap();
      do_simple(3'd4, 8'hFF, "load_pc_ff");
      do_simple(3'd5, 8'h00, "inc_pc_wrap");
      checks++;
      if (pc !== 8'h00) begin
         errors++;
         $display("FAIL inc_pc_wrap_const actual=%h required=00", pc);
      end
      do_simple(3'd4, 8'hFF, "load_pc_ff_again");
      do_access(3'd1, 1'b0, 8'h00, 0, 8'h5A, "fetch_ff");
      checks++;
      if (pc !== 8'h00) begin
         errors++;
         $display("FAIL fetch_ff_wrap actual=%h required=00", pc);
      end
   endtask

   task automatic test_timeout();
      do_access(3'd1, 1'b0, 8'h00, 20, 8'h00, "timeout_read");
      checks++;
      if ({mem_err, bus_out} !== {1'b1, m_bus_out}) begin
         errors++;
         $display("FAIL timeout_flag actual=%h required=%h", {mem_err, bus_out}, {1'b1, m_bus_out});
      end
      do_access(3'd1, 1'b1, 8'h00, 14, 8'hC3, "ack_on_last_cycle");
      do_simple(3'd0, 8'h00, "err_sticky");
   endtask

   task automatic test_reset_during_access();
      @(negedge clock);
      memory_op = MEM_READ;
      data_word_selector = 1'b0;
      mem_ack = 1'b0;
      @(negedge clock);
      memory_op = MEM_NOP;
      @(negedge clock);
      apply_reset(3'd1, 1'b1, "reset_in_access");
      @(negedge clock);
      checks++;
      if ({mem_req, stall, bus_out} !== {1'b0, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL reset_in_access_after actual=%h required=000", {mem_req, stall, bus_out});
      end
   endtask

   task automatic test_random();
      logic [2:0] op;
      int         wait_n;
      for (int i = 0; i < 80; i++) begin
         op = 3'($urandom_range(0, 7));
         if (op == 3'd1 || op == 3'd2) begin
            wait_n = ($urandom_range(0, 7) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 4);
            do_access(op, 1'($urandom), 8'($urandom), wait_n, 8'($urandom), "rand_access");
         end else begin
            do_simple(op, 8'($urandom), "rand_simple");
         end
      end
   endtask

   task automatic test_back_to_back();
      do_simple(3'd4, 8'hFE, "b2b_load_pc");
      for (int i = 0; i < 4; i++) begin
         do_access(3'd1, 1'b0, 8'h00, 0, 8'($urandom), "b2b_fetch");
      end
      checks++;
      if (pc !== 8'h02) begin
         errors++;
         $display("FAIL b2b_pc actual=%h required=02", pc);
      end
   endtask

   initial begin
      reset = 1'b0;
      memory_op = MEM_NOP;
      data_word_selector = 1'b0;
      bus_selector = 1'b0;
      bus = 8'h00;
      mem_rdata = 8'h00;
      mem_ack = 1'b0;
      model_reset();
      test_reset();
      test_fetch_and_write();
      test_pc_wrap();
      test_timeout();
      test_reset_during_access();
      test_random();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
